if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder/controller.
- Holds the PC and issues one instruction-memory read at a time.
- Captures the returned 32-bit word into an instruction register and presents it to decode with a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution and squashes any stale fetch.

Parameters:
- ADDR_W, 32, width of PC and imem address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment applied to PC after each accepted fetch.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_addr  output  ADDR_W  read address, equals pc while imem_req_valid.
- imem_rsp_valid  input  1  read data valid, exactly one per accepted request, ≥1 cycle after acceptance.
- imem_rsp_data  input  32  read data.
- instr  output  32  instruction to decode.
- instr_pc  output  ADDR_W  address instr was fetched from.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode consumes instr this cycle.
- redirect_valid  input  1  load new PC.
- redirect_pc  input  ADDR_W  target PC.

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high. rst overrides all other inputs in the cycle it is sampled, including mid-request.
- Reset values:
  - pc=RESET_PC, state=REQ, squash=0.
  - instr=0, instr_pc=0, instr_valid=0.
  - imem_req_valid=0 during the rst cycle, 1 from the first cycle after rst deasserts.
  - Any response arriving after reset for a pre-reset request is discarded: squash=1 if reset hit in WAIT.
- FSM states: REQ, WAIT, HOLD.
- REQ:
  - Outputs: imem_req_valid=1, imem_addr=pc.
  - imem_req_ready=1 → WAIT.
  - Otherwise stay in REQ.
- WAIT:
  - Outputs: imem_req_valid=0.
  - On imem_rsp_valid with squash=0: instr<=imem_rsp_data, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_STEP (mod 2^ADDR_W, wrap from all-ones), → HOLD.
  - On imem_rsp_valid with squash=1: data dropped, squash<=0, → REQ.
- HOLD:
  - Output: instr_valid=1.
  - instr_ready=1 → instr_valid<=0, → REQ. Next request issues the cycle after the handshake.
  - instr, instr_pc stable while instr_valid=1 and instr_ready=0.
- Throughput: max one instruction per 3 cycles with a 1-cycle memory. Latency from acceptance to instr_valid = memory latency + 1.
- Redirect (redirect_valid=1) takes priority over normal PC update in every state:
  - REQ, imem_req_ready=0: pc<=redirect_pc, stay REQ. imem_addr changes next cycle; memory must tolerate this.
  - REQ, imem_req_ready=1: the accepted request is stale; pc<=redirect_pc, squash<=1, → WAIT.
  - WAIT, no rsp: pc<=redirect_pc, squash<=1.
  - WAIT, rsp same cycle: response dropped, pc<=redirect_pc, → REQ.
  - HOLD: instr_valid<=0 regardless of instr_ready, pc<=redirect_pc, → REQ.
- Redirect with squash already 1: squash stays 1, pc updated.
- No alignment check: redirect_pc used verbatim.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- With the macro, two extra outputs:
  - fetch_cnt (32): +1 per instr_valid&&instr_ready handshake.
  - stall_cnt (32): +1 per cycle with instr_valid=1 and instr_ready=0.
  - Both reset to 0 on rst and wrap at 2^32.
- Without the macro: ports and counter logic absent; all other behaviour identical.

Test Plan:
- Reset, then 1-cycle-latency memory returning addr-as-data, instr_ready tied 1 → instr_pc sequence 0x0,0x4,0x8; instr_valid every 3rd cycle; instr matches.
- Hold instr_ready=0 for 5 cycles in HOLD with instr=0x012A4020 → instr, instr_pc stable, no new imem_req_valid. Release → next request at pc+4.
- imem_req_ready low 4 cycles → imem_req_valid stays 1, imem_addr stable at 0x10.
- redirect_valid with redirect_pc=0x100 while in WAIT, response arrives 2 cycles later → response dropped, next imem_addr=0x100, next instr_pc=0x100.
- Redirect to 0x200 in HOLD with instr_ready=1 same cycle → instr_valid drops, no handshake counted, next fetch at 0x200.
- redirect_pc=0xFFFF_FFFC then one fetch → next fetch address 0x0 (wrap). With IF_PERF_CNT_EN: fetch_cnt increments, stall_cnt matches counted stall cycles.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: imem request/response, decode handshake and PC redirect.
// master = fetch stage, slave = memory/decode/branch side.
interface if_fetch_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_addr, instr, instr_pc, instr_valid,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr, instr_pc, instr_valid,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, instruction register toward decode.
// Optional perf counters (fetch_cnt, stall_cnt) enabled with `define IF_PERF_CNT_EN.
module if_fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  if_fetch_stage_if.master   bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              squash_q, squash_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StReq;
      pc_q          <= RESET_PC;
      // A request still in flight at reset will answer later and must be dropped.
      squash_q      <= (state_q == StWait) && !bus.imem_rsp_valid;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    squash_d      = squash_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    unique case (state_q)
      StReq: begin
        // Late response to a pre-reset request arriving before the new request goes out.
        if (squash_q && bus.imem_rsp_valid) squash_d = 1'b0;
        if (bus.imem_req_ready) begin
          state_d = StWait;
          if (bus.redirect_valid) squash_d = 1'b1;
        end
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
      end
      StWait: begin
        if (bus.imem_rsp_valid) begin
          if (bus.redirect_valid) begin
            pc_d     = bus.redirect_pc;
            squash_d = 1'b0;
            state_d  = StReq;
          end else if (squash_q) begin
            squash_d = 1'b0;
            state_d  = StReq;
          end else begin
            instr_d       = bus.imem_rsp_data;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + ADDR_W'(PC_STEP);
            state_d       = StHold;
          end
        end else if (bus.redirect_valid) begin
          pc_d     = bus.redirect_pc;
          squash_d = 1'b1;
        end
      end
      StHold: begin
        if (bus.redirect_valid) begin
          pc_d          = bus.redirect_pc;
          instr_valid_d = 1'b0;
          state_d       = StReq;
        end else if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  assign bus.imem_req_valid = (state_q == StReq) && !rst;
  assign bus.imem_addr      = pc_q;
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;
  assign bus.instr_valid    = instr_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      // A redirect in HOLD kills the instruction, so it is not a completed fetch.
      if (instr_valid_q && bus.instr_ready && !bus.redirect_valid) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (instr_valid_q && !bus.instr_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small latency-configurable imem responder.
module tb_if_fetch_stage;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_stage_if #(.ADDR_W(AW)) bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  if_fetch_stage #(
    .ADDR_W  (AW),
    .RESET_PC(32'h0),
    .PC_STEP (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt(fetch_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  int total = 0;
  int bad = 0;

  // Memory responder state
  int          mem_lat = 1;
  logic        mem_rdy = 1'b1;
  int          pend = 0;
  logic [31:0] pend_addr = '0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = '0;

  // One clock: present this cycle's memory inputs, clock, return at the next negedge.
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    bus.imem_req_ready = mem_rdy;
    if (pend == 1) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = ovr_en ? ovr_data : pend_addr;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    #1;
    acc = bus.imem_req_valid && bus.imem_req_ready;
    a   = bus.imem_addr;
    @(posedge clk);
    if (pend > 0) pend--;
    if (acc) begin
      pend      = mem_lat;
      pend_addr = a;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++;
      $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++;
      $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); end
    total++; if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin bad++;
      $display("FAIL reset_instr: got %h/%h want 0/0", bus.instr, bus.instr_pc); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++;
      $display("FAIL reset_pc: got %h want 0", bus.imem_addr); end
`ifdef IF_PERF_CNT_EN
    total++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin bad++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", fetch_cnt, stall_cnt); end
`endif
    rst = 1'b0;
    #1;
    total++; if (bus.imem_req_valid !== 1'b1) begin bad++;
      $display("FAIL post_reset_req: got %b want 1", bus.imem_req_valid); end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_pc;
    int n = 0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      total++; if (bus.instr_valid !== ((i % 3) == 1)) begin bad++;
        $display("FAIL seq_valid[%0d]: got %b want %b", i, bus.instr_valid, ((i % 3) == 1)); end
      if ((i % 3) == 1) begin
        exp_pc = 32'(n * 4);
        n++;
        total++; if (bus.instr_pc !== exp_pc || bus.instr !== exp_pc) begin bad++;
          $display("FAIL seq_instr[%0d]: got pc %h data %h want %h", i, bus.instr_pc, bus.instr,
                   exp_pc); end
      end
    end
  endtask

  task automatic test_stall();
    bus.instr_ready = 1'b0;
    ovr_en   = 1'b1;
    ovr_data = 32'h012A_4020;
    cycle();
    cycle();
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h012A_4020 ||
                   bus.instr_pc !== 32'hC) begin bad++;
        $display("FAIL stall_hold[%0d]: got v=%b %h @%h want 1 012a4020 @0000000c", i,
                 bus.instr_valid, bus.instr, bus.instr_pc); end
      total++; if (bus.imem_req_valid !== 1'b0) begin bad++;
        $display("FAIL stall_noreq[%0d]: got %b want 0", i, bus.imem_req_valid); end
      cycle();
    end
    ovr_en = 1'b0;
    bus.instr_ready = 1'b1;
    cycle();
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h10) begin bad++;
      $display("FAIL stall_release: got v=%b addr %h want 1 00000010", bus.imem_req_valid,
               bus.imem_addr); end
`ifdef IF_PERF_CNT_EN
    total++; if (fetch_cnt !== 32'd4 || stall_cnt !== 32'd5) begin bad++;
      $display("FAIL stall_cnt: got %0d/%0d want 4/5", fetch_cnt, stall_cnt); end
`endif
  endtask

  task automatic test_req_stall();
    mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h10) begin bad++;
        $display("FAIL req_stall[%0d]: got v=%b addr %h want 1 00000010", i,
                 bus.imem_req_valid, bus.imem_addr); end
    end
    mem_rdy = 1'b1;
    cycle();
    cycle();
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h10 || bus.instr !== 32'h10)
      begin bad++;
      $display("FAIL req_stall_fetch: got v=%b %h @%h want 1 00000010 @00000010",
               bus.instr_valid, bus.instr, bus.instr_pc); end
    cycle();
  endtask

  task automatic test_redirect_wait();
    mem_lat = 3;
    cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    cycle();
    bus.redirect_valid = 1'b0;
    cycle();
    cycle();
    total++; if (bus.instr_valid !== 1'b0) begin bad++;
      $display("FAIL redir_wait_drop: got %b want 0", bus.instr_valid); end
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h100) begin bad++;
      $display("FAIL redir_wait_addr: got v=%b addr %h want 1 00000100", bus.imem_req_valid,
               bus.imem_addr); end
    mem_lat = 1;
    cycle();
    cycle();
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100 || bus.instr !== 32'h100)
      begin bad++;
      $display("FAIL redir_wait_fetch: got v=%b %h @%h want 1 00000100 @00000100",
               bus.instr_valid, bus.instr, bus.instr_pc); end
    cycle();
  endtask

  task automatic test_redirect_hold();
    cycle();
    cycle();
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h104) begin bad++;
      $display("FAIL redir_hold_pre: got v=%b @%h want 1 @00000104", bus.instr_valid,
               bus.instr_pc); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    bus.instr_ready    = 1'b1;
    cycle();
    bus.redirect_valid = 1'b0;
    total++; if (bus.instr_valid !== 1'b0) begin bad++;
      $display("FAIL redir_hold_drop: got %b want 0", bus.instr_valid); end
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h200) begin bad++;
      $display("FAIL redir_hold_addr: got v=%b addr %h want 1 00000200", bus.imem_req_valid,
               bus.imem_addr); end
`ifdef IF_PERF_CNT_EN
    total++; if (fetch_cnt !== 32'd6) begin bad++;
      $display("FAIL redir_hold_cnt: got %0d want 6", fetch_cnt); end
`endif
  endtask

  task automatic test_wrap();
    mem_rdy = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    bus.redirect_valid = 1'b0;
    total++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin bad++;
      $display("FAIL wrap_redirect: got %h want fffffffc", bus.imem_addr); end
    mem_rdy = 1'b1;
    cycle();
    cycle();
    total++; if (bus.instr_pc !== 32'hFFFF_FFFC || bus.instr !== 32'hFFFF_FFFC) begin bad++;
      $display("FAIL wrap_fetch: got %h @%h want fffffffc @fffffffc", bus.instr, bus.instr_pc);
      end
    cycle();
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin bad++;
      $display("FAIL wrap_next: got v=%b addr %h want 1 00000000", bus.imem_req_valid,
               bus.imem_addr); end
`ifdef IF_PERF_CNT_EN
    total++; if (fetch_cnt !== 32'd7 || stall_cnt !== 32'd5) begin bad++;
      $display("FAIL wrap_cnt: got %0d/%0d want 7/5", fetch_cnt, stall_cnt); end
`endif
  endtask

  task automatic test_redirect_req_accept();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    cycle();
    bus.redirect_valid = 1'b0;
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++;
      $display("FAIL redir_req_wait: got %b want 0", bus.imem_req_valid); end
    cycle();
    total++; if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 ||
                 bus.imem_addr !== 32'h300) begin bad++;
      $display("FAIL redir_req_drop: got iv=%b rv=%b addr %h want 0 1 00000300",
               bus.instr_valid, bus.imem_req_valid, bus.imem_addr); end
    cycle();
    cycle();
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h300 || bus.instr !== 32'h300)
      begin bad++;
      $display("FAIL redir_req_fetch: got v=%b %h @%h want 1 00000300 @00000300",
               bus.instr_valid, bus.instr, bus.instr_pc); end
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    test_reset();
    test_sequence();
    test_stall();
    test_req_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_redirect_req_accept();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
